multi_cycle_control_unit: RTL and testbench
===========================================

Name: multi_cycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder for the 16-bit, 4-bit-opcode ISA. Supported opcodes: R-type, addi, andi, ori, subi, lhw, shw, beq, bne, blt, bgt, jmp.
- A registered FSM sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory with a ready handshake.
- Adds three things the single-cycle decoder lacks: per-instruction state sequencing, memory stall handling with a watchdog, and a sticky fault state for illegal opcodes.
- Sits between the instruction register (op source) and the multi-cycle datapath muxes and enables.

Parameters:
- OP_WIDTH, 4: opcode width.
- ALUOP_WIDTH, 4: alu_op width.
- WAIT_LIMIT, 15: maximum consecutive cycles with mem_ready low in FETCH or MEM before FAULT. 0 disables the watchdog.
- CNT_WIDTH, 32: width of the optional performance counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- op  in  OP_WIDTH  opcode from the instruction register; stable after ir_write.
- mem_ready  in  1  memory access completes this cycle.
- branch_cond  in  1  ALU comparison result for the current alu_op.
- pc_write  out  1  PC load enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALU-out register (branch target), 10 jump target.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  memory address: 0 PC, 1 ALU-out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  write-back data: 0 ALU-out, 1 MDR.
- reg_dst  out  1  destination register: 1 rd, 0 rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 PC, 1 regA.
- alu_src_b  out  2  ALU B input: 00 regB, 01 const 1, 10 ext imm, 11 ext imm branch offset.
- alu_op  out  ALUOP_WIDTH  ALU operation.
- sign_ext  out  1  1 sign-extend, 0 zero-extend immediate.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 illegal opcode, 10 memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- State is registered. Outputs are combinational from state, op, mem_ready and branch_cond.
- Reset: while rst is high, every output is 0 and state_dbg shows FETCH. On the first edge with rst high: state goes to FETCH, the wait counter clears, and fault/fault_code clear. Reset mid-instruction aborts with no write strobes.
- FETCH (0):
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0001.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay in FETCH.
- DECODE (1):
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=0001, sign_ext=1.
  - op 0000-0100 go to EXEC. op 0111/1000 go to ADDR. op 1001-1100 go to BRANCH.
  - op 1111: pc_write=1, pc_src=10, go to FETCH.
  - op 0101/0110/1101/1110 go to FAULT with fault_code=01.
- EXEC (2):
  - Outputs: alu_src_a=1; alu_src_b=00 for R-type, 10 otherwise; alu_op=0000 for R-type, op otherwise.
  - sign_ext=1 for addi/subi, 0 otherwise.
  - Next state ALU_WB.
- ALU_WB (3): reg_write=1, mem_to_reg=0, reg_dst=1 only for R-type. Next state FETCH.
- ADDR (4): alu_src_a=1, alu_src_b=10, alu_op=op, sign_ext=1. Next state MEM.
- MEM (5):
  - Outputs: i_or_d=1; mem_read=1 for lhw, mem_write=1 for shw. Strobes are held until mem_ready.
  - On mem_ready: lhw goes to MEM_WB, shw goes to FETCH.
- MEM_WB (6): reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- BRANCH (7):
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=op, sign_ext=1, pc_src=01, pc_write=branch_cond.
  - Next state FETCH.
- FAULT (8): all control outputs are 0, fault=1. Exits only on rst.
- Watchdog:
  - Counter increments each FETCH/MEM cycle with mem_ready low and clears on mem_ready or any state change.
  - When the counter equals WAIT_LIMIT while mem_ready is still low, the next state is FAULT with fault_code=10.
  - mem_ready arriving in that same cycle wins: the access completes, no fault.
- Unlisted outputs are 0 in each state. There are no latches; every output has a default.

Optional Feature:
- Macro: MCU_PERF_CNT_EN.
- When defined, adds outputs retired_cnt[CNT_WIDTH-1:0] and stall_cnt[CNT_WIDTH-1:0], both cleared by rst.
- retired_cnt increments on each transition into FETCH from ALU_WB, MEM_WB, MEM(shw), BRANCH or DECODE(jmp).
- stall_cnt increments on each FETCH/MEM cycle with mem_ready low.
- Both counters wrap at 2^CNT_WIDTH.
- When not defined, the ports and logic are absent.

Test Plan:
- add (op=0000), mem_ready always 1 -> states 0,1,2,3,0. reg_write=1 with reg_dst=1 only in ALU_WB. Total 4 cycles.
- lhw (op=0111), mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles in MEM. MEM_WB gives reg_write=1, mem_to_reg=1. No fault.
- beq (op=1001) with branch_cond=0, then bne with branch_cond=1 -> pc_write=0 in the first BRANCH. pc_write=1 with pc_src=01 in the second.
- Illegal op=0101 -> DECODE goes to FAULT, fault=1, fault_code=01. Outputs stay 0 for 20 cycles. rst high for 1 cycle -> FETCH, fault=0.
- WAIT_LIMIT=15, mem_ready held 0 in FETCH -> FAULT with fault_code=10 after 16 cycles. A repeat run with mem_ready=1 on the limit cycle -> DECODE, no fault.
- MCU_PERF_CNT_EN defined: jmp, subi, shw with one stall -> retired_cnt=3, stall_cnt=1.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle FSM controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory-stall watchdog, sticky fault.
// Optional perf counters (retired/stall) are built when MCU_PERF_CNT_EN is defined.
module multi_cycle_control_unit #(
  parameter int OP_WIDTH    = 4,
  parameter int ALUOP_WIDTH = 4,
  parameter int WAIT_LIMIT  = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic                   mem_ready,
  input  logic                   branch_cond,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   ir_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   sign_ext,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [3:0]             state_dbg
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   retired_cnt,
  output logic [CNT_WIDTH-1:0]   stall_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALU_WB = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM    = 4'd5,
    S_MEM_WB = 4'd6,
    S_BRANCH = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(4'h0);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(4'h1);
  localparam logic [OP_WIDTH-1:0] OP_ANDI  = OP_WIDTH'(4'h2);
  localparam logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(4'h3);
  localparam logic [OP_WIDTH-1:0] OP_SUBI  = OP_WIDTH'(4'h4);
  localparam logic [OP_WIDTH-1:0] OP_LHW   = OP_WIDTH'(4'h7);
  localparam logic [OP_WIDTH-1:0] OP_SHW   = OP_WIDTH'(4'h8);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(4'h9);
  localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] OP_BLT   = OP_WIDTH'(4'hB);
  localparam logic [OP_WIDTH-1:0] OP_BGT   = OP_WIDTH'(4'hC);
  localparam logic [OP_WIDTH-1:0] OP_JMP   = OP_WIDTH'(4'hF);

  localparam int              WCW  = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0]  WLIM = WCW'(WAIT_LIMIT);

  state_t         state, next_state;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     fault_code_q, fault_code_d;
  logic           stall, timeout;

  assign stall   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign timeout = stall && (WAIT_LIMIT != 0) && (wait_cnt == WLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state        <= next_state;
      fault_code_q <= fault_code_d;
      // Counts only consecutive stalled cycles in the same state.
      if (stall && (next_state == state)) wait_cnt <= wait_cnt + 1'b1;
      else                                wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state   = state;
    fault_code_d = fault_code_q;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = '0;
    sign_ext     = 1'b0;
    fault        = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALUOP_WIDTH'(1);
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end else if (timeout) begin
            next_state   = S_FAULT;
            fault_code_d = 2'b10;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = ALUOP_WIDTH'(1);
          sign_ext  = 1'b1;
          case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: next_state = S_EXEC;
            OP_LHW, OP_SHW:                              next_state = S_ADDR;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT:              next_state = S_BRANCH;
            OP_JMP: begin
              pc_write   = 1'b1;
              pc_src     = 2'b10;
              next_state = S_FETCH;
            end
            default: begin
              next_state   = S_FAULT;
              fault_code_d = 2'b01;
            end
          endcase
        end
        S_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = (op == OP_RTYPE) ? 2'b00 : 2'b10;
          alu_op     = (op == OP_RTYPE) ? '0 : ALUOP_WIDTH'(op);
          sign_ext   = (op == OP_ADDI) || (op == OP_SUBI);
          next_state = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (op == OP_RTYPE);
          next_state = S_FETCH;
        end
        S_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          alu_op     = ALUOP_WIDTH'(op);
          sign_ext   = 1'b1;
          next_state = S_MEM;
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (op == OP_LHW);
          mem_write = (op == OP_SHW);
          if (mem_ready) begin
            next_state = (op == OP_LHW) ? S_MEM_WB : S_FETCH;
          end else if (timeout) begin
            next_state   = S_FAULT;
            fault_code_d = 2'b10;
          end
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_WIDTH'(op);
          sign_ext   = 1'b1;
          pc_src     = 2'b01;
          pc_write   = branch_cond;
          next_state = S_FETCH;
        end
        S_FAULT: fault = 1'b1;
        default: next_state = S_FETCH;
      endcase
    end
  end

  assign fault_code = rst ? 2'b00 : fault_code_q;
  assign state_dbg  = rst ? 4'd0  : state;

`ifdef MCU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      // Any arc back into FETCH marks a completed instruction; FAULT never takes one.
      if ((state != S_FETCH) && (next_state == S_FETCH)) retired_cnt <= retired_cnt + 1'b1;
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: per-cycle expected state/control vectors queued and compared.
// Perf-counter scenario is built when MCU_PERF_CNT_EN is defined.
module tb_multi_cycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op;
  logic       mem_ready, branch_cond;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, sign_ext, fault;
  logic [1:0] pc_src, alu_src_b, fault_code;
  logic [3:0] alu_op, state_dbg;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  multi_cycle_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .branch_cond(branch_cond),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_ext(sign_ext), .fault(fault),
    .fault_code(fault_code), .state_dbg(state_dbg)
`ifdef MCU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw, iod, mr, mw, m2r, rd, rw, asa;
    logic [1:0] asb;
    logic [3:0] aop;
    logic       se, f;
    logic [1:0] fc;
  } vec_t;

  typedef struct {
    logic       r;
    logic [3:0] o;
    logic       rdy;
    logic       bc;
    vec_t       e;
  } step_t;

  step_t tbl[$];
  vec_t  exp_q[$];
  vec_t  got, ex;
  int    n_chk = 0;
  int    n_bad = 0;

  // Expected control vectors, one per state, taken from the state output table.
  function automatic vec_t x_zero();
    vec_t v = '0;
    return v;
  endfunction
  function automatic vec_t x_fetch(logic rdy);
    vec_t v = '0;
    v.st = 4'd0; v.mr = 1'b1; v.asb = 2'b01; v.aop = 4'b0001;
    v.irw = rdy; v.pcw = rdy;
    return v;
  endfunction
  function automatic vec_t x_decode(logic [3:0] o);
    vec_t v = '0;
    v.st = 4'd1; v.asb = 2'b11; v.aop = 4'b0001; v.se = 1'b1;
    if (o == 4'hF) begin v.pcw = 1'b1; v.pcs = 2'b10; end
    return v;
  endfunction
  function automatic vec_t x_exec(logic [3:0] o);
    vec_t v = '0;
    v.st = 4'd2; v.asa = 1'b1;
    v.asb = (o == 4'h0) ? 2'b00 : 2'b10;
    v.aop = (o == 4'h0) ? 4'h0 : o;
    v.se  = (o == 4'h1) || (o == 4'h4);
    return v;
  endfunction
  function automatic vec_t x_aluwb(logic [3:0] o);
    vec_t v = '0;
    v.st = 4'd3; v.rw = 1'b1; v.rd = (o == 4'h0);
    return v;
  endfunction
  function automatic vec_t x_addr(logic [3:0] o);
    vec_t v = '0;
    v.st = 4'd4; v.asa = 1'b1; v.asb = 2'b10; v.aop = o; v.se = 1'b1;
    return v;
  endfunction
  function automatic vec_t x_mem(logic [3:0] o);
    vec_t v = '0;
    v.st = 4'd5; v.iod = 1'b1; v.mr = (o == 4'h7); v.mw = (o == 4'h8);
    return v;
  endfunction
  function automatic vec_t x_memwb();
    vec_t v = '0;
    v.st = 4'd6; v.rw = 1'b1; v.m2r = 1'b1;
    return v;
  endfunction
  function automatic vec_t x_branch(logic [3:0] o, logic bc);
    vec_t v = '0;
    v.st = 4'd7; v.asa = 1'b1; v.aop = o; v.se = 1'b1; v.pcs = 2'b01; v.pcw = bc;
    return v;
  endfunction
  function automatic vec_t x_fault(logic [1:0] c);
    vec_t v = '0;
    v.st = 4'd8; v.f = 1'b1; v.fc = c;
    return v;
  endfunction

  function automatic vec_t obs();
    vec_t v;
    v.st = state_dbg; v.pcw = pc_write; v.pcs = pc_src; v.irw = ir_write;
    v.iod = i_or_d; v.mr = mem_read; v.mw = mem_write; v.m2r = mem_to_reg;
    v.rd = reg_dst; v.rw = reg_write; v.asa = alu_src_a; v.asb = alu_src_b;
    v.aop = alu_op; v.se = sign_ext; v.f = fault; v.fc = fault_code;
    return v;
  endfunction

  task automatic add(input logic r, input logic [3:0] o, input logic rdy, input logic bc, input vec_t e);
    tbl.push_back('{r, o, rdy, bc, e});
  endtask

  task automatic drive(input step_t s);
    rst = s.r; op = s.o; mem_ready = s.rdy; branch_cond = s.bc;
    exp_q.push_back(s.e);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tbl.delete();
    add(1, 4'h0, 1, 1, x_zero());
    add(1, 4'h7, 0, 1, x_zero());
    add(1, 4'hF, 1, 0, x_zero());
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_rtype_add();
    tbl.delete();
    add(0, 4'h0, 1, 0, x_fetch(1));
    add(0, 4'h0, 1, 0, x_decode(4'h0));
    add(0, 4'h0, 1, 0, x_exec(4'h0));
    add(0, 4'h0, 1, 0, x_aluwb(4'h0));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL add[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_imm_ops();
    tbl.delete();
    foreach (tbl[i]) tbl.delete(i);
    add(0, 4'h1, 1, 0, x_fetch(1));
    add(0, 4'h1, 1, 0, x_decode(4'h1));
    add(0, 4'h1, 1, 0, x_exec(4'h1));
    add(0, 4'h1, 1, 0, x_aluwb(4'h1));
    add(0, 4'h3, 1, 0, x_fetch(1));
    add(0, 4'h3, 1, 0, x_decode(4'h3));
    add(0, 4'h3, 1, 0, x_exec(4'h3));
    add(0, 4'h3, 1, 0, x_aluwb(4'h3));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL imm[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_lhw_stall();
    tbl.delete();
    add(0, 4'h7, 1, 0, x_fetch(1));
    add(0, 4'h7, 1, 0, x_decode(4'h7));
    add(0, 4'h7, 1, 0, x_addr(4'h7));
    for (int k = 0; k < 3; k++) add(0, 4'h7, 0, 0, x_mem(4'h7));
    add(0, 4'h7, 1, 0, x_mem(4'h7));
    add(0, 4'h7, 1, 0, x_memwb());
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL lhw[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_branches();
    tbl.delete();
    add(0, 4'h9, 1, 0, x_fetch(1));
    add(0, 4'h9, 1, 0, x_decode(4'h9));
    add(0, 4'h9, 1, 0, x_branch(4'h9, 0));
    add(0, 4'hA, 1, 1, x_fetch(1));
    add(0, 4'hA, 1, 1, x_decode(4'hA));
    add(0, 4'hA, 1, 1, x_branch(4'hA, 1));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    tbl.delete();
    add(0, 4'hF, 1, 0, x_fetch(1));
    add(0, 4'hF, 1, 0, x_decode(4'hF));
    add(0, 4'h8, 1, 0, x_fetch(1));
    add(0, 4'h8, 1, 0, x_decode(4'h8));
    add(0, 4'h8, 1, 0, x_addr(4'h8));
    add(0, 4'h8, 1, 0, x_mem(4'h8));
    add(0, 4'h2, 1, 0, x_fetch(1));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  // 15 stalled cycles, then mem_ready lands on the limit cycle: access completes.
  task automatic test_wdog_near_miss();
    tbl.delete();
    add(0, 4'h2, 1, 0, x_decode(4'h2));
    add(0, 4'h2, 1, 0, x_exec(4'h2));
    add(0, 4'h2, 1, 0, x_aluwb(4'h2));
    for (int k = 0; k < 15; k++) add(0, 4'h0, 0, 0, x_fetch(0));
    add(0, 4'h0, 1, 0, x_fetch(1));
    add(0, 4'h0, 1, 0, x_decode(4'h0));
    add(0, 4'h0, 1, 0, x_exec(4'h0));
    add(0, 4'h0, 1, 0, x_aluwb(4'h0));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL wdog_miss[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_fetch_timeout();
    tbl.delete();
    for (int k = 0; k < 16; k++) add(0, 4'h0, 0, 0, x_fetch(0));
    add(0, 4'h0, 1, 1, x_fault(2'b10));
    add(0, 4'h7, 0, 0, x_fault(2'b10));
    add(1, 4'h0, 0, 0, x_zero());
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL fetch_to[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_mem_timeout();
    tbl.delete();
    add(0, 4'h7, 1, 0, x_fetch(1));
    add(0, 4'h7, 1, 0, x_decode(4'h7));
    add(0, 4'h7, 1, 0, x_addr(4'h7));
    for (int k = 0; k < 16; k++) add(0, 4'h7, 0, 0, x_mem(4'h7));
    add(0, 4'h7, 1, 0, x_fault(2'b10));
    add(1, 4'h7, 1, 0, x_zero());
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL mem_to[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    tbl.delete();
    add(0, 4'h5, 1, 0, x_fetch(1));
    add(0, 4'h5, 1, 0, x_decode(4'h5));
    for (int k = 0; k < 20; k++)
      add(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x_fault(2'b01));
    add(1, 4'h5, 1, 1, x_zero());
    add(0, 4'h5, 0, 0, x_fetch(0));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL illegal[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    tbl.delete();
    add(0, 4'h0, 1, 0, x_fetch(1));
    add(0, 4'h0, 1, 0, x_decode(4'h0));
    add(0, 4'h0, 1, 0, x_exec(4'h0));
    add(1, 4'h0, 1, 0, x_zero());
    add(0, 4'h0, 0, 0, x_fetch(0));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL rst_mid[%0d] got=%h exp=%h", i, got, ex); end
      next_cycle();
    end
  endtask

`ifdef MCU_PERF_CNT_EN
  task automatic test_perf();
    tbl.delete();
    add(1, 4'h0, 1, 0, x_zero());
    add(0, 4'hF, 1, 0, x_fetch(1));
    add(0, 4'hF, 1, 0, x_decode(4'hF));
    add(0, 4'h4, 1, 0, x_fetch(1));
    add(0, 4'h4, 1, 0, x_decode(4'h4));
    add(0, 4'h4, 1, 0, x_exec(4'h4));
    add(0, 4'h4, 1, 0, x_aluwb(4'h4));
    add(0, 4'h8, 1, 0, x_fetch(1));
    add(0, 4'h8, 1, 0, x_decode(4'h8));
    add(0, 4'h8, 1, 0, x_addr(4'h8));
    add(0, 4'h8, 0, 0, x_mem(4'h8));
    add(0, 4'h8, 1, 0, x_mem(4'h8));
    add(0, 4'h0, 0, 0, x_fetch(0));
    foreach (tbl[i]) begin
      drive(tbl[i]); got = obs(); ex = exp_q.pop_front(); n_chk++;
      if (got !== ex) begin n_bad++; $display("FAIL perf_seq[%0d] got=%h exp=%h", i, got, ex); end
      if (i == tbl.size() - 1) begin
        n_chk++;
        if (retired_cnt !== 32'd3) begin n_bad++; $display("FAIL retired_cnt got=%0d exp=3", retired_cnt); end
        n_chk++;
        if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL stall_cnt got=%0d exp=1", stall_cnt); end
      end
      next_cycle();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op = 4'h0; mem_ready = 1'b0; branch_cond = 1'b0;
    next_cycle();
    test_reset();
    test_rtype_add();
    test_imm_ops();
    test_lhw_stall();
    test_branches();
    test_back_to_back();
    test_wdog_near_miss();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid();
`ifdef MCU_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
